// File: rtl/conv_window_pkg.sv
// rtl/conv_window_pkg.sv - shared widths and tap packing for the 3x3 window generator
package conv_window_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_K    = 3;
    localparam int WIN_TAPS = 9;
    localparam int WIN_BITS = 72;

    // Tap k = row*3+col sits at bit k*PIX_W of the packed window.
    function automatic int tap_offset(input int row, input int col);
        return (row * WIN_K + col) * PIX_W;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - single-port row buffer, combinational read-old, registered write
module conv_line_buffer
    import conv_window_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to 3x3 valid-window stream; SOF checking under CONV_WINDOW_GEN_SOF_CHECK_EN
module conv_window_gen
    import conv_window_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pixel_valid,
    input  logic [PIX_W-1:0]    i_pixel_data,
    input  logic                i_sof,
    output logic                o_data_valid,
    output logic [WIN_BITS-1:0] o_data,
    output logic                o_frame_done,
    output logic                o_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [CW-1:0]    cur_c;
    logic [RW-1:0]    cur_r;
    logic [PIX_W-1:0] a_rd;
    logic [PIX_W-1:0] b_rd;
    logic             win_emit;
    logic [PIX_W-1:0] win [WIN_K][WIN_K];

    // An SOF pixel is treated as (0,0) in the same cycle it arrives.
    assign cur_c    = i_sof ? '0 : col;
    assign cur_r    = i_sof ? '0 : row;
    assign win_emit = i_pixel_valid && (cur_r >= RW'(2)) && (cur_c >= CW'(2));

    conv_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb_a (
        .clk   (i_clk),
        .we    (i_pixel_valid),
        .addr  (cur_c),
        .wdata (b_rd),
        .rdata (a_rd)
    );

    conv_line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb_b (
        .clk   (i_clk),
        .we    (i_pixel_valid),
        .addr  (cur_c),
        .wdata (i_pixel_data),
        .rdata (b_rd)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col          <= '0;
            row          <= '0;
            o_data_valid <= 1'b0;
            o_frame_done <= 1'b0;
            for (int r = 0; r < WIN_K; r++) begin
                for (int c = 0; c < WIN_K; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            o_data_valid <= win_emit;
            o_frame_done <= win_emit && (cur_r == R_LAST) && (cur_c == C_LAST);
            if (i_pixel_valid) begin
                for (int r = 0; r < WIN_K; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= a_rd;
                win[1][2] <= b_rd;
                win[2][2] <= i_pixel_data;
                if (cur_c == C_LAST) begin
                    col <= '0;
                    row <= (cur_r == R_LAST) ? '0 : cur_r + RW'(1);
                end else begin
                    col <= cur_c + CW'(1);
                    row <= cur_r;
                end
            end
        end
    end

    // The window registers only move on accepted pixels, so o_data holds while idle.
    for (genvar r = 0; r < WIN_K; r++) begin : g_row
        for (genvar c = 0; c < WIN_K; c++) begin : g_col
            assign o_data[tap_offset(r, c) +: PIX_W] = win[r][c];
        end
    end

`ifdef CONV_WINDOW_GEN_SOF_CHECK_EN
    logic first_pix;
    logic err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            first_pix <= 1'b1;
            err       <= 1'b0;
        end else if (i_pixel_valid) begin
            first_pix <= 1'b0;
            if (i_sof && (col != '0 || row != '0)) begin
                err <= 1'b1;
            end
            if (!i_sof && col == '0 && row == '0 && !first_pix) begin
                err <= 1'b1;
            end
        end
    end

    assign o_err = err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen (4x4 and 28x28 instances)
module tb_conv_window_gen;

    typedef struct {
        logic [71:0] data;
        logic        fd;
    } exp_t;

    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       vld;
        logic       win;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, pv0, sof0, ov0, ofd0, oerr0;
    logic [7:0]  pd0;
    logic [71:0] od0;
    logic        rst1, pv1, sof1, ov1, ofd1, oerr1;
    logic [7:0]  pd1;
    logic [71:0] od1;

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut0 (
        .i_clk(clk), .i_rst(rst0), .i_pixel_valid(pv0), .i_pixel_data(pd0), .i_sof(sof0),
        .o_data_valid(ov0), .o_data(od0), .o_frame_done(ofd0), .o_err(oerr0)
    );

    conv_window_gen #(.IMG_W(28), .IMG_H(28), .PIX_W(8)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_pixel_valid(pv1), .i_pixel_data(pd1), .i_sof(sof1),
        .o_data_valid(ov1), .o_data(od1), .o_frame_done(ofd1), .o_err(oerr1)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [71:0] cap0[$];
    int          wcnt0 = 0, wcnt1 = 0, fdcnt0 = 0, fdcnt1 = 0, consec0 = 0;
    logic        prev0 = 1'b0;
    exp_t        me0, me1;
    logic [7:0]  img [2][28][28];
    int          mr[2], mc[2];
    vec_t        tbl[16];
    int          exp_wins;
    logic        exp_err;

    task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Frame-buffer reference: keeps the whole image and cuts windows out of it.
    task automatic model(int d, logic [7:0] p, logic s);
        int   w = (d != 0) ? 28 : 4;
        exp_t e;
        if (s) begin
            mr[d] = 0;
            mc[d] = 0;
        end
        img[d][mr[d]][mc[d]] = p;
        if (mr[d] >= 2 && mc[d] >= 2) begin
            e.data = '0;
            for (int rr = 0; rr < 3; rr++)
                for (int cc = 0; cc < 3; cc++)
                    e.data[(rr*3+cc)*8 +: 8] = img[d][mr[d]-2+rr][mc[d]-2+cc];
            e.fd = (mr[d] == w-1) && (mc[d] == w-1);
            if (d == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (mc[d] == w-1) begin
            mc[d] = 0;
            mr[d] = (mr[d] == w-1) ? 0 : mr[d] + 1;
        end else begin
            mc[d] = mc[d] + 1;
        end
    endtask

    task automatic send(int d, logic [7:0] p, logic s, logic v);
        @(posedge clk); #1;
        if (d == 0) begin
            pd0 = p; sof0 = s; pv0 = v; pv1 = 1'b0;
        end else begin
            pd1 = p; sof1 = s; pv1 = v; pv0 = 1'b0;
        end
        if (v) model(d, p, s);
    endtask

    task automatic idle(int n);
        repeat (n) send(0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset0();
        @(posedge clk); #1;
        rst0 = 1'b1; pv0 = 1'b0; sof0 = 1'b0;
        q0.delete();
        @(posedge clk); #1;
        rst0 = 1'b0;
        mr[0] = 0;
        mc[0] = 0;
    endtask

    task automatic apply(logic [7:0] base, bit half);
        for (int i = 0; i < 16; i++) begin
            send(0, base + tbl[i].pix, tbl[i].sof, tbl[i].vld);
            if (half) send(0, 8'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic clear0();
        wcnt0 = 0; fdcnt0 = 0; consec0 = 0;
        cap0.delete();
    endtask

    function automatic logic [71:0] mkwin(int base);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(r*3+c)*8 +: 8] = 8'(base + r*4 + c);
        return w;
    endfunction

    always @(negedge clk) begin
        if (ov0) begin
            wcnt0++;
            cap0.push_back(od0);
            if (prev0) consec0++;
            if (ofd0) fdcnt0++;
            if (q0.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL dut0 unexpected window: got %0h want none", od0);
            end else begin
                me0 = q0.pop_front();
                chk("dut0 window", od0, me0.data);
                chk("dut0 frame_done", ofd0, me0.fd);
            end
        end else if (ofd0) begin
            n_vec++; n_bad++;
            $display("FAIL dut0 frame_done without window: got 1 want 0");
        end
        prev0 = ov0;
    end

    always @(negedge clk) begin
        if (ov1) begin
            wcnt1++;
            if (ofd1) fdcnt1++;
            if (q1.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL dut1 unexpected window: got %0h want none", od1);
            end else begin
                me1 = q1.pop_front();
                chk("dut1 window", od1, me1.data);
                chk("dut1 frame_done", ofd1, me1.fd);
            end
        end
    end

    initial begin
        rst0 = 1'b1; pv0 = 1'b0; sof0 = 1'b0; pd0 = '0;
        rst1 = 1'b1; pv1 = 1'b0; sof1 = 1'b0; pd1 = '0;
        mr[0] = 0; mc[0] = 0; mr[1] = 0; mc[1] = 0;
        exp_wins = 0;
        for (int i = 0; i < 16; i++) begin
            tbl[i].pix = 8'(i);
            tbl[i].sof = (i == 0);
            tbl[i].vld = 1'b1;
            tbl[i].win = (i / 4 >= 2) && (i % 4 >= 2);
            if (tbl[i].win) exp_wins++;
        end
`ifdef CONV_WINDOW_GEN_SOF_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        chk("reset valid", ov0, 0);
        chk("reset data", od0, 0);
        chk("reset frame_done", ofd0, 0);
        chk("reset err", oerr0, 0);
        chk("reset valid dut1", ov1, 0);

        // Single 4x4 frame, continuous valid
        clear0();
        apply(8'd0, 1'b0);
        idle(4);
        chk("A count", wcnt0, exp_wins);
        chk("A first", cap0[0], mkwin(0));
        chk("A last", cap0[3], mkwin(5));
        chk("A frame_done count", fdcnt0, 1);
        chk("A err", oerr0, 0);

        // Same frame with valid low every other cycle
        clear0();
        apply(8'd0, 1'b1);
        idle(4);
        chk("B count", wcnt0, 4);
        chk("B consecutive valids", consec0, 0);
        chk("B first", cap0[0], mkwin(0));
        chk("B last", cap0[3], mkwin(5));

        // Back-to-back frames
        clear0();
        apply(8'd0, 1'b0);
        apply(8'd100, 1'b0);
        idle(4);
        chk("C count", wcnt0, 8);
        chk("C frame2 first", cap0[4], mkwin(100));
        chk("C frame_done count", fdcnt0, 2);
        chk("C drain", q0.size(), 0);

        // Reset after pixel 9, then a fresh frame
        clear0();
        for (int i = 0; i < 10; i++) send(0, 8'(i), i == 0, 1'b1);
        do_reset0();
        chk("D reset valid", ov0, 0);
        chk("D reset data", od0, 0);
        apply(8'd50, 1'b0);
        idle(4);
        chk("D count", wcnt0, 4);
        chk("D first", cap0[0], mkwin(50));
        chk("D last", cap0[3], mkwin(55));

        // SOF mid-frame at pixel 6: counters restart there
        clear0();
        chk("E err before", oerr0, 0);
        for (int i = 0; i < 6; i++) send(0, 8'(i), i == 0, 1'b1);
        send(0, 8'd6, 1'b1, 1'b1);
        send(0, 8'd7, 1'b0, 1'b1);
        chk("E err next cycle", oerr0, exp_err);
        for (int i = 8; i < 22; i++) send(0, 8'(i), 1'b0, 1'b1);
        idle(4);
        chk("E err held", oerr0, exp_err);
        chk("E count", wcnt0, 4);
        chk("E first", cap0[0], mkwin(6));
        do_reset0();
        chk("E err cleared", oerr0, 0);

        // 28x28 random frame
        for (int i = 0; i < 784; i++) send(1, 8'($urandom), i == 0, 1'b1);
        idle(4);
        chk("F count", wcnt1, 676);
        chk("F frame_done count", fdcnt1, 1);
        chk("F drain", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
